data_sram_slave: RTL and testbench

SRAM-like bus responder that serves the pipeline's data-side requests (the port whose `data_sram_data_ok`/`data_sram_rdata` the MEM stage consumes). It accepts requests with `addr_ok`, performs the access on an internal word-addressed memory, and returns `data_ok` (with `rdata` for loads) strictly in order after a fixed latency. It sits at the SoC top between the CPU data port and on-chip RAM, and serves as the reference responder in the CPU bench.

---
 rtl/data_sram_slave.sv | 130 +++++++++++++
 tb/tb_data_sram_slave.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_slave.sv
// data_sram_slave
// SRAM-like responder for the CPU data port. Requests are accepted with
// data_sram_addr_ok and performed on an internal word-addressed memory at the
// accept edge. Each request is then answered with data_sram_data_ok, plus
// data_sram_rdata for loads, strictly in acceptance order after LATENCY cycles.
//
// Parameters
//   ADDR_WIDTH  : word-address bits; memory holds 2**ADDR_WIDTH 32-bit words
//   QUEUE_DEPTH : maximum outstanding requests (power of 2, >= 2)
//   LATENCY     : cycles from accept edge to data_ok (>= 1)
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   data_sram_req       : request valid
//   data_sram_wr        : 1 = store, 0 = load
//   data_sram_size      : access size (informational only)
//   data_sram_addr      : byte address; bits [ADDR_WIDTH+1:2] select the word
//   data_sram_wstrb     : byte write enables for stores
//   data_sram_wdata     : store data
//   data_sram_addr_ok   : request accepted this cycle
//   data_sram_data_ok   : response for the oldest outstanding request
//   data_sram_rdata     : load data, valid with data_ok (zero otherwise)
//   resp_hold           : while high, no response issues (entries keep aging)
module data_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        resp_hold
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(QUEUE_DEPTH);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic [QUEUE_DEPTH-1:0] q_valid;
  logic [QUEUE_DEPTH-1:0] q_load;
  logic [31:0]            q_rdata [QUEUE_DEPTH];
  logic [CNT_W-1:0]       q_cnt   [QUEUE_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;
  logic                  pop;
  logic                  unused_bits;

  assign word_idx = data_sram_addr[ADDR_WIDTH+1:2];

  // Size and the address bits outside the word index carry no meaning here.
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2],
                         data_sram_addr[1:0]};

  // Acceptance looks only at the registered count: a pop in the same cycle
  // does not free a slot for a new request until the following cycle.
  assign data_sram_addr_ok = !reset && data_sram_req && (count < DEPTH_C);
  assign accept            = data_sram_req && data_sram_addr_ok;

  // The head answers once its latency counter has run out and the throttle
  // is released; nothing here depends on the incoming request.
  assign data_sram_data_ok = !reset && q_valid[head] && (q_cnt[head] == '0) && !resp_hold;
  assign pop               = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && q_load[head]) ? q_rdata[head] : 32'h0;

  // Stores update memory at the accept edge, byte lanes gated by wstrb.
  // Memory is deliberately not reset so data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response queue: every valid entry ages toward zero, the head retires on
  // data_ok and a newly accepted request is written at the tail. Load data
  // is captured at accept time, which keeps loads ordered behind older stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_valid[i] && (q_cnt[i] != '0)) begin
          q_cnt[i] <= q_cnt[i] - 1'b1;
        end
      end

      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end

      if (accept) begin
        q_valid[tail] <= 1'b1;
        q_load[tail]  <= !data_sram_wr;
        q_rdata[tail] <= data_sram_wr ? 32'h0 : mem[word_idx];
        q_cnt[tail]   <= CNT_INIT;
        tail          <= tail + 1'b1;
      end

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave
// Directed bench for data_sram_slave. Three instances share one set of
// request inputs: u_l2 (LATENCY 2), u_l8 (LATENCY 8) and u_l1 (LATENCY 1),
// all with QUEUE_DEPTH 4. Each scenario task checks one instance.
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        resp_hold;

  logic        addr_ok_a, data_ok_a;
  logic [31:0] rdata_a;
  logic        addr_ok_b, data_ok_b;
  logic [31:0] rdata_b;
  logic        addr_ok_c, data_ok_c;
  logic [31:0] rdata_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_WIDTH(10), .QUEUE_DEPTH(4), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_a),
    .data_sram_data_ok(data_ok_a), .data_sram_rdata(rdata_a), .resp_hold(resp_hold)
  );

  data_sram_slave #(.ADDR_WIDTH(10), .QUEUE_DEPTH(4), .LATENCY(8)) u_l8 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_b),
    .data_sram_data_ok(data_ok_b), .data_sram_rdata(rdata_b), .resp_hold(resp_hold)
  );

  data_sram_slave #(.ADDR_WIDTH(10), .QUEUE_DEPTH(4), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata), .data_sram_addr_ok(addr_ok_c),
    .data_sram_data_ok(data_ok_c), .data_sram_rdata(rdata_c), .resp_hold(resp_hold)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge of the same cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = d;
  endtask

  task automatic set_idle();
    req   = 1'b0;
    wr    = 1'b0;
    addr  = 32'h0;
    wstrb = 4'h0;
    wdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    next_cycle();
    reset = 1'b0;
  endtask

  // Outputs stay low during reset even with a request pending, and the
  // first idle cycle after reset produces nothing.
  task automatic test_reset();
    reset = 1'b1;
    set_req(1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({addr_ok_a, data_ok_a, addr_ok_b, data_ok_b, addr_ok_c, data_ok_c} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got aok/dok l2 %b%b l8 %b%b l1 %b%b, want all 0",
               addr_ok_a, data_ok_a, addr_ok_b, data_ok_b, addr_ok_c, data_ok_c);
    end
    n_checks++;
    if ({rdata_a, rdata_b, rdata_c} !== 96'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rdata: got %h %h %h, want 0", rdata_a, rdata_b, rdata_c);
    end
    next_cycle();
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if ({addr_ok_a, data_ok_a} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got aok/dok %b/%b, want 0/0", addr_ok_a, data_ok_a);
    end
    next_cycle();
  endtask

  // Word store then load of the same address on u_l2.
  task automatic test_store_load();
    logic [33:0] exp_v [5];
    exp_v = '{ {1'b1, 1'b0, 32'h0}, {1'b1, 1'b0, 32'h0}, {1'b0, 1'b1, 32'h0},
               {1'b0, 1'b1, 32'h1122_3344}, {1'b0, 1'b0, 32'h0} };
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       set_req(1'b1, 32'h100, 4'hF, 32'h1122_3344);
        1:       set_req(1'b0, 32'h100, 4'h0, 32'h0);
        default: set_idle();
      endcase
      @(negedge clk);
      n_checks++;
      if ({addr_ok_a, data_ok_a, rdata_a} !== exp_v[c]) begin
        n_fail++;
        $display("[TB] FAIL store_load cycle %0d: got aok/dok/rdata %b/%b/%h, want %b/%b/%h",
                 c, addr_ok_a, data_ok_a, rdata_a, exp_v[c][33], exp_v[c][32], exp_v[c][31:0]);
      end
      next_cycle();
    end
  endtask

  // Byte-lane store, a zero-strobe store that must still be answered, then
  // a load of the merged word.
  task automatic test_byte_store();
    logic [33:0] exp_v [6];
    exp_v = '{ {1'b1, 1'b0, 32'h0}, {1'b1, 1'b0, 32'h0}, {1'b1, 1'b1, 32'h0},
               {1'b0, 1'b1, 32'h0}, {1'b0, 1'b1, 32'h1122_AB44}, {1'b0, 1'b0, 32'h0} };
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       set_req(1'b1, 32'h101, 4'b0010, 32'h0000_AB00);
        1:       set_req(1'b1, 32'h100, 4'b0000, 32'hFFFF_FFFF);
        2:       set_req(1'b0, 32'h100, 4'h0, 32'h0);
        default: set_idle();
      endcase
      @(negedge clk);
      n_checks++;
      if ({addr_ok_a, data_ok_a, rdata_a} !== exp_v[c]) begin
        n_fail++;
        $display("[TB] FAIL byte_store cycle %0d: got aok/dok/rdata %b/%b/%h, want %b/%b/%h",
                 c, addr_ok_a, data_ok_a, rdata_a, exp_v[c][33], exp_v[c][32], exp_v[c][31:0]);
      end
      next_cycle();
    end
  endtask

  // u_l8: with four loads outstanding addr_ok drops until the first pop
  // has taken effect; responses come back in address order.
  task automatic test_queue_full();
    int          idx;
    logic        exp_aok, exp_dok;
    logic [31:0] exp_rd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 32'h200 + 32'(4 * i), 4'hF, 32'hA500_0000 + 32'(i));
      next_cycle();
    end
    set_idle();
    repeat (12) next_cycle();
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      set_req(1'b0, 32'h200 + 32'(4 * (idx % 4)), 4'h0, 32'h0);
      exp_aok = (k <= 3) || (k >= 9);
      exp_dok = (k >= 8);
      exp_rd  = exp_dok ? 32'hA500_0000 + 32'(k - 8) : 32'h0;
      @(negedge clk);
      n_checks++;
      if ({addr_ok_b, data_ok_b, rdata_b} !== {exp_aok, exp_dok, exp_rd}) begin
        n_fail++;
        $display("[TB] FAIL queue_full k=%0d: got aok/dok/rdata %b/%b/%h, want %b/%b/%h",
                 k, addr_ok_b, data_ok_b, rdata_b, exp_aok, exp_dok, exp_rd);
      end
      if (exp_aok) idx++;
      next_cycle();
    end
    set_idle();
    repeat (20) next_cycle();
  endtask

  // Three loads held back for ten cycles, then released one per cycle.
  task automatic test_resp_hold();
    logic [31:0] exp_rd [3];
    exp_rd = '{32'h1122_AB44, 32'hCAFE_0001, 32'hCAFE_0002};
    do_reset();
    set_req(1'b1, 32'h104, 4'hF, 32'hCAFE_0001);
    next_cycle();
    set_req(1'b1, 32'h108, 4'hF, 32'hCAFE_0002);
    next_cycle();
    set_idle();
    repeat (3) next_cycle();
    resp_hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) set_req(1'b0, 32'h100 + 32'(4 * c), 4'h0, 32'h0);
      else       set_idle();
      @(negedge clk);
      n_checks++;
      if (data_ok_a !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL resp_hold held cycle %0d: got data_ok %b, want 0", c, data_ok_a);
      end
      next_cycle();
    end
    resp_hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({data_ok_a, rdata_a} !== {(c < 3), (c < 3) ? exp_rd[c % 3] : 32'h0}) begin
        n_fail++;
        $display("[TB] FAIL resp_hold release R+%0d: got dok/rdata %b/%h, want %b/%h",
                 c, data_ok_a, rdata_a, (c < 3), (c < 3) ? exp_rd[c % 3] : 32'h0);
      end
      next_cycle();
    end
  endtask

  // Reset with two loads outstanding discards them; memory keeps its data
  // and the queue is fully free again afterwards.
  task automatic test_reset_outstanding();
    set_req(1'b1, 32'h300, 4'hF, 32'h5A5A_1234);
    next_cycle();
    set_idle();
    repeat (3) next_cycle();
    set_req(1'b0, 32'h300, 4'h0, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (data_ok_a !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outstanding in_reset: got data_ok %b, want 0", data_ok_a);
    end
    next_cycle();
    reset = 1'b0;
    resp_hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_req(1'b0, 32'h300, 4'h0, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({addr_ok_a, data_ok_a} !== {(c < 4), 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL reset_outstanding refill %0d: got aok/dok %b/%b, want %b/0",
                 c, addr_ok_a, data_ok_a, (c < 4));
      end
      next_cycle();
    end
    set_idle();
    resp_hold = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({data_ok_a, rdata_a} !== {(c < 4), (c < 4) ? 32'h5A5A_1234 : 32'h0}) begin
        n_fail++;
        $display("[TB] FAIL reset_outstanding drain %0d: got dok/rdata %b/%h, want %b/%h",
                 c, data_ok_a, rdata_a, (c < 4), (c < 4) ? 32'h5A5A_1234 : 32'h0);
      end
      next_cycle();
    end
  endtask

  // u_l1: 20 back-to-back store/load pairs, wrapping the queue pointers.
  task automatic test_back_to_back_wrap();
    logic        exp_aok, exp_dok;
    logic [31:0] exp_rd;
    do_reset();
    for (int c = 0; c < 42; c++) begin
      if (c < 40) begin
        if (c % 2 == 0) set_req(1'b1, 32'h400 + 32'(4 * (c / 2)), 4'hF,
                                32'hD000_0000 | 32'((c / 2) * 32'h0001_0101));
        else            set_req(1'b0, 32'h400 + 32'(4 * (c / 2)), 4'h0, 32'h0);
      end else begin
        set_idle();
      end
      exp_aok = (c < 40);
      exp_dok = (c >= 1) && (c <= 40);
      exp_rd  = (exp_dok && ((c - 1) % 2 == 1)) ?
                (32'hD000_0000 | 32'(((c - 1) / 2) * 32'h0001_0101)) : 32'h0;
      @(negedge clk);
      n_checks++;
      if ({addr_ok_c, data_ok_c, rdata_c} !== {exp_aok, exp_dok, exp_rd}) begin
        n_fail++;
        $display("[TB] FAIL wrap cycle %0d: got aok/dok/rdata %b/%b/%h, want %b/%b/%h",
                 c, addr_ok_c, data_ok_c, rdata_c, exp_aok, exp_dok, exp_rd);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset     = 1'b1;
    resp_hold = 1'b0;
    size      = 2'd2;
    set_idle();
    next_cycle();
    test_reset();
    test_store_load();
    test_byte_store();
    test_queue_full();
    test_resp_hold();
    test_reset_outstanding();
    test_back_to_back_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
